// File: rtl/alu_input_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_input_sequencer_if
//  Description : Operand/opcode bus and start/done handshake between the
//                input sequencer (master) and the SimpleALU (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_input_sequencer_if;
    logic [7:0]  OpA;
    logic [7:0]  OpB;
    logic [2:0]  OpCode;
    logic        alu_start;
    logic [15:0] alu_result;
    logic        alu_done;

    modport master (
        output OpA, OpB, OpCode, alu_start,
        input  alu_result, alu_done
    );

    modport slave (
        input  OpA, OpB, OpCode, alu_start,
        output alu_result, alu_done
    );
endinterface
`default_nettype wire

// File: rtl/alu_input_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_input_sequencer
//  Description : Debounces three active-low buttons, loads operands/opcode
//                from switches, runs one ALU operation per execute press with
//                a start/done handshake and millisecond timeout, and latches
//                the result for display.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_input_sequencer #(
    parameter int CLK_HZ      = 50000000,
    parameter int DEBOUNCE_MS = 20,
    parameter int TIMEOUT_MS  = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    alu_input_sequencer_if.master        alu,
    input  logic [7:0]                   SW,
    input  logic [2:0]                   KEY_n,
    output logic [7:0]                   OpReg,
    output logic                         ShowOpReg,
    output logic                         ShowOpCode,
    output logic [15:0]                  OpResult,
    output logic                         result_valid,
    output logic                         busy,
    output logic                         timeout_err,
    output logic                         oneMsPulse
);

    localparam int c_MS_CYC = CLK_HZ / 1000;
    localparam int c_MS_W   = (c_MS_CYC > 1) ? $clog2(c_MS_CYC) : 1;
    localparam logic [c_MS_W-1:0] c_MS_MAX = c_MS_W'(c_MS_CYC - 1);

    localparam int c_DB_W = $clog2(DEBOUNCE_MS + 1);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_MS - 1);

    localparam int c_TO_W = $clog2(TIMEOUT_MS + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_MS - 1);

    // Button bit positions
    localparam int c_KEY_LOAD = 0;
    localparam int c_KEY_CODE = 1;
    localparam int c_KEY_EXEC = 2;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    logic [c_MS_W-1:0] r_ms_cnt;
    logic [2:0]        r_sync1;
    logic [2:0]        r_sync2;
    logic [2:0]        r_stable;
    logic [2:0]        r_press;
    logic [c_DB_W-1:0] r_db_cnt [3];

    state_t            r_state,     w_state_nxt;
    logic              r_sel_b,     w_sel_b_nxt;
    logic [7:0]        r_opa,       w_opa_nxt;
    logic [7:0]        r_opb,       w_opb_nxt;
    logic [2:0]        r_opcode,    w_opcode_nxt;
    logic [7:0]        r_opreg,     w_opreg_nxt;
    logic              r_show_reg,  w_show_reg_nxt;
    logic              r_show_code, w_show_code_nxt;
    logic              r_start,     w_start_nxt;
    logic [15:0]       r_result,    w_result_nxt;
    logic              r_res_valid, w_res_valid_nxt;
    logic              r_to_err,    w_to_err_nxt;
    logic [c_TO_W-1:0] r_to_cnt,    w_to_cnt_nxt;

    // Free-running millisecond timebase; the pulse marks the terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ms_cnt <= '0;
        else if (r_ms_cnt == c_MS_MAX)
            r_ms_cnt <= '0;
        else
            r_ms_cnt <= r_ms_cnt + 1'b1;
    end

    assign oneMsPulse = (r_ms_cnt == c_MS_MAX);

    // Synchronize, debounce on ms ticks and emit a one-cycle press on 1->0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '1;
            r_sync2  <= '1;
            r_stable <= '1;
            r_press  <= '0;
            for (int i = 0; i < 3; i++)
                r_db_cnt[i] <= '0;
        end else begin
            r_sync1 <= KEY_n;
            r_sync2 <= r_sync1;
            r_press <= '0;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (oneMsPulse) begin
                    // This tick brings the count to DEBOUNCE_MS: accept level
                    if (r_db_cnt[i] == c_DB_LAST) begin
                        r_stable[i] <= r_sync2[i];
                        r_db_cnt[i] <= '0;
                        r_press[i]  <= ~r_sync2[i];
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Register the FSM state together with every registered output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sel_b     <= 1'b0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_opcode    <= '0;
            r_opreg     <= '0;
            r_show_reg  <= 1'b0;
            r_show_code <= 1'b0;
            r_start     <= 1'b0;
            r_result    <= '0;
            r_res_valid <= 1'b0;
            r_to_err    <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel_b     <= w_sel_b_nxt;
            r_opa       <= w_opa_nxt;
            r_opb       <= w_opb_nxt;
            r_opcode    <= w_opcode_nxt;
            r_opreg     <= w_opreg_nxt;
            r_show_reg  <= w_show_reg_nxt;
            r_show_code <= w_show_code_nxt;
            r_start     <= w_start_nxt;
            r_result    <= w_result_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_to_err    <= w_to_err_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
        end
    end

    // Next-state and output decode; execute outranks load, load outranks opcode
    always_comb begin
        w_state_nxt     = r_state;
        w_sel_b_nxt     = r_sel_b;
        w_opa_nxt       = r_opa;
        w_opb_nxt       = r_opb;
        w_opcode_nxt    = r_opcode;
        w_opreg_nxt     = r_opreg;
        w_show_reg_nxt  = 1'b0;
        w_show_code_nxt = 1'b0;
        w_start_nxt     = 1'b0;
        w_result_nxt    = r_result;
        w_res_valid_nxt = 1'b0;
        w_to_err_nxt    = r_to_err;
        w_to_cnt_nxt    = r_to_cnt;

        case (r_state)
            S_IDLE: begin
                if (r_press[c_KEY_EXEC]) begin
                    w_start_nxt  = 1'b1;
                    w_state_nxt  = S_BUSY;
                    w_to_cnt_nxt = '0;
                    w_to_err_nxt = 1'b0;
                end else if (r_press[c_KEY_LOAD]) begin
                    w_opreg_nxt    = SW;
                    w_show_reg_nxt = 1'b1;
                    w_sel_b_nxt    = ~r_sel_b;
                    if (r_sel_b)
                        w_opb_nxt = SW;
                    else
                        w_opa_nxt = SW;
                end else if (r_press[c_KEY_CODE]) begin
                    w_opcode_nxt    = r_opcode + 3'd1;
                    w_show_code_nxt = 1'b1;
                end
            end
            S_BUSY: begin
                // A completion in the same cycle as the timeout still wins
                if (alu.alu_done) begin
                    w_result_nxt    = alu.alu_result;
                    w_res_valid_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end else if (oneMsPulse) begin
                    if (r_to_cnt == c_TO_LAST) begin
                        w_result_nxt = 16'hFFFF;
                        w_to_err_nxt = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_to_cnt_nxt = r_to_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign alu.OpA       = r_opa;
    assign alu.OpB       = r_opb;
    assign alu.OpCode    = r_opcode;
    assign alu.alu_start = r_start;

    assign OpReg         = r_opreg;
    assign ShowOpReg     = r_show_reg;
    assign ShowOpCode    = r_show_code;
    assign OpResult      = r_result;
    assign result_valid  = r_res_valid;
    assign timeout_err   = r_to_err;
    assign busy          = (r_state == S_BUSY);

endmodule
`default_nettype wire

// File: doc/alu_input_sequencer.md
Name: alu_input_sequencer

Overview:
- Front-end controller for the SimpleALU. Debounces three active-low pushbuttons and loads operands A/B and the opcode from switches.
- Sequences one ALU operation per execute press using a start/done handshake with a timeout, and latches the ALU result.
- Generates the oneMsPulse, OpReg/ShowOpReg, OpCode/ShowOpCode and OpResult signals consumed by display_driver.

Parameters:
CLK_HZ, 50000000, clock frequency; ms tick period = CLK_HZ/1000 cycles
DEBOUNCE_MS, 20, consecutive ms ticks a raw button level must differ from the stable level before it is accepted
TIMEOUT_MS, 10, ms ticks allowed in BUSY before abort

Ports:
clk  input  1  system clock
rst_n  input  1  reset; one clock domain, reset is asynchronous and active-low
SW  input  8  operand switches
KEY_n  input  3  raw active-low buttons: [0] load operand, [1] next opcode, [2] execute
alu_result  input  16  ALU output, valid when alu_done=1
alu_done  input  1  one-cycle completion pulse from the ALU
OpA  output  8  operand A to ALU
OpB  output  8  operand B to ALU
OpCode  output  3  opcode to ALU and display
alu_start  output  1  one-cycle start pulse
OpReg  output  8  last loaded operand value (display)
ShowOpReg  output  1  one-cycle pulse, operand loaded
ShowOpCode  output  1  one-cycle pulse, opcode changed
OpResult  output  16  latched result
result_valid  output  1  one-cycle pulse when OpResult updates
busy  output  1  high in BUSY
timeout_err  output  1  sticky abort flag
oneMsPulse  output  1  one-cycle pulse every ms

Behaviour:
- Reset (async, rst_n low): all outputs 0, operand select = A, state IDLE, all counters 0, debounced stable levels = 1 (released).
- ms tick: counter runs 0..CLK_HZ/1000-1. oneMsPulse is high for exactly the cycle the counter equals max, then the counter wraps to 0.
- Button conditioning, per bit:
  - 2-flop synchronizer on KEY_n.
  - Counter increments on oneMsPulse while the synced level differs from the stable level; it clears whenever they match.
  - When the counter reaches DEBOUNCE_MS, the stable level takes the synced value and the counter clears.
  - A stable 1->0 transition produces an internal one-cycle press; release produces nothing.
- Press arbitration: when multiple presses occur in the same cycle, priority is execute > load > opcode. Lower-priority presses in that cycle are discarded.
- FSM states: IDLE, BUSY.
- IDLE, load press:
  - OpReg<=SW. If select=A then OpA<=SW, else OpB<=SW. Select toggles.
  - ShowOpReg=1 in the first cycle the new OpReg is visible, i.e. registered together with the update.
- IDLE, opcode press: OpCode<=OpCode+1 (3-bit wrap, 7->0). ShowOpCode=1 registered together with the update.
- IDLE, execute press:
  - alu_start=1 for one cycle, registered. Next state BUSY, busy=1.
  - Timeout counter clears; timeout_err clears.
- BUSY:
  - Load and opcode presses are discarded. OpA/OpB/OpCode hold.
  - Execute presses are discarded.
  - alu_done=1: OpResult<=alu_result, result_valid=1 on the same edge, return to IDLE.
  - Otherwise the timeout counter increments on oneMsPulse. On reaching TIMEOUT_MS without done: OpResult<=16'hFFFF, timeout_err<=1, result_valid stays 0, return to IDLE.
  - alu_done and the timeout in the same cycle: done wins, timeout_err stays 0.
- alu_done in IDLE is ignored; OpResult is unchanged.
- Widths: all counters are sized to hold their maximum without overflow. OpResult, OpA and OpB are pure latches with no arithmetic.

Test Plan:
- Use CLK_HZ=10000 (10 cycles/ms), DEBOUNCE_MS=2, TIMEOUT_MS=3 for all scenarios.
- Reset then idle 100 cycles -> oneMsPulse every 10th cycle; all other outputs stay 0.
- SW=8'h3C, KEY_n[0] low 40 cycles with 1-cycle glitches first -> exactly one ShowOpReg, OpA=8'h3C, OpReg=8'h3C. SW=8'hA5, second press -> OpB=8'hA5, OpA unchanged.
- Eight KEY_n[1] presses -> OpCode steps 1..7 then wraps to 0; eight ShowOpCode pulses total.
- KEY_n[2] press, model returns alu_done with alu_result=16'h1234 five cycles after alu_start -> one alu_start pulse; busy for those cycles; OpResult=16'h1234; one result_valid pulse. A load press during BUSY changes nothing.
- Execute with no alu_done -> after 3 ms ticks OpResult=16'hFFFF, timeout_err=1, busy=0. The next execute clears timeout_err.
- Execute and load debounce-complete in the same cycle -> only alu_start is issued; OpA/OpB unchanged and no ShowOpReg. Assert rst_n low mid-BUSY -> outputs zero immediately (asynchronous reset).
